// File: rtl/sprite_mover.sv
`timescale 1ns/1ps
// sprite_mover: erases, moves (with screen-edge clamping) and redraws one sprite
// through the VGA plot port. Define SPRITE_MOVER_ERASE_EN to compile the erase pass.
module sprite_mover #(
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COL_W     = 3,
   parameter int SPR_W     = 20,
   parameter int SPR_H     = 20,
   parameter int STEP      = 7,
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int INIT_X    = 0,
   parameter int INIT_Y    = 100,
   parameter int BG_COLOUR = 0,
   parameter int TRANSP    = 7
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             go,
   input  logic             load,
   input  logic [X_W-1:0]   load_x,
   input  logic [Y_W-1:0]   load_y,
   input  logic             left,
   input  logic             right,
   input  logic             up,
   input  logic             down,
   output logic [4:0]       pix_col,
   output logic [4:0]       pix_row,
   output logic [1:0]       orient,
   input  logic [COL_W-1:0] pix_colour,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [COL_W-1:0] colour,
   output logic             plot,
   output logic [X_W-1:0]   pos_x,
   output logic [Y_W-1:0]   pos_y,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef SPRITE_MOVER_ERASE_EN
      S_ERASE,
`endif
      S_MOVE,
      S_DRAW,
      S_DONE
   } state_t;

   localparam logic [X_W:0]     X_MAX    = (X_W+1)'(SCREEN_W - SPR_W);
   localparam logic [Y_W:0]     Y_MAX    = (Y_W+1)'(SCREEN_H - SPR_H);
   localparam logic [X_W:0]     STEP_X   = (X_W+1)'(STEP);
   localparam logic [Y_W:0]     STEP_Y   = (Y_W+1)'(STEP);
   localparam logic [4:0]       COL_LAST = 5'(SPR_W - 1);
   localparam logic [4:0]       ROW_LAST = 5'(SPR_H - 1);
   localparam logic [COL_W-1:0] BG_C     = COL_W'(BG_COLOUR);
   localparam logic [COL_W-1:0] TRANSP_C = COL_W'(TRANSP);

   localparam logic [1:0] OR_RIGHT = 2'b00;
   localparam logic [1:0] OR_LEFT  = 2'b01;
   localparam logic [1:0] OR_DOWN  = 2'b10;
   localparam logic [1:0] OR_UP    = 2'b11;

   state_t         state_q, state_d;
   logic [X_W-1:0] pos_x_q, pos_x_d;
   logic [Y_W-1:0] pos_y_q, pos_y_d;
   logic [1:0]     orient_q, orient_d;
   logic [4:0]     col_q, col_d;
   logic [4:0]     row_q, row_d;
   logic           flush_q, flush_d;
   logic [X_W-1:0] vga_x_q, vga_x_d;
   logic [Y_W-1:0] vga_y_q, vga_y_d;
   logic           erase_v_q, erase_v_d;
   logic           draw_v_q, draw_v_d;

   logic           pix_run;
   logic [X_W:0]   x_sub, x_add, lx_ext;
   logic [Y_W:0]   y_sub, y_add, ly_ext;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         pos_x_q   <= X_W'(INIT_X);
         pos_y_q   <= Y_W'(INIT_Y);
         orient_q  <= OR_RIGHT;
         col_q     <= '0;
         row_q     <= '0;
         flush_q   <= 1'b0;
         vga_x_q   <= '0;
         vga_y_q   <= '0;
         erase_v_q <= 1'b0;
         draw_v_q  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         orient_q  <= orient_d;
         col_q     <= col_d;
         row_q     <= row_d;
         flush_q   <= flush_d;
         vga_x_q   <= vga_x_d;
         vga_y_q   <= vga_y_d;
         erase_v_q <= erase_v_d;
         draw_v_q  <= draw_v_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output is defaulted first so no path can infer a latch.
      state_d   = state_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      orient_d  = orient_q;
      col_d     = col_q;
      row_d     = row_q;
      flush_d   = flush_q;
      erase_v_d = 1'b0;
      draw_v_d  = 1'b0;
      pix_run   = 1'b0;
      vga_x_d   = pos_x_q + X_W'(col_q);
      vga_y_d   = pos_y_q + Y_W'(row_q);

      // One extra bit so a borrow or carry is visible before clamping.
      x_sub  = {1'b0, pos_x_q} - STEP_X;
      x_add  = {1'b0, pos_x_q} + STEP_X;
      y_sub  = {1'b0, pos_y_q} - STEP_Y;
      y_add  = {1'b0, pos_y_q} + STEP_Y;
      lx_ext = {1'b0, load_x};
      ly_ext = {1'b0, load_y};

      case (state_q)
         S_IDLE: begin
            if (go) begin
`ifdef SPRITE_MOVER_ERASE_EN
               state_d = S_ERASE;
`else
               state_d = S_MOVE;
`endif
            end else if (load) begin
               pos_x_d = (lx_ext > X_MAX) ? X_MAX[X_W-1:0] : load_x;
               pos_y_d = (ly_ext > Y_MAX) ? Y_MAX[Y_W-1:0] : load_y;
            end
         end
`ifdef SPRITE_MOVER_ERASE_EN
         S_ERASE: begin
            if (flush_q) begin
               flush_d = 1'b0;
               state_d = S_MOVE;
            end else begin
               pix_run   = 1'b1;
               erase_v_d = 1'b1;
            end
         end
`endif
         S_MOVE: begin
            if (!up) begin
               pos_y_d  = y_sub[Y_W] ? '0 : y_sub[Y_W-1:0];
               orient_d = OR_UP;
            end else if (!down) begin
               pos_y_d  = (y_add > Y_MAX) ? Y_MAX[Y_W-1:0] : y_add[Y_W-1:0];
               orient_d = OR_DOWN;
            end else if (!left) begin
               pos_x_d  = x_sub[X_W] ? '0 : x_sub[X_W-1:0];
               orient_d = OR_LEFT;
            end else if (!right) begin
               pos_x_d  = (x_add > X_MAX) ? X_MAX[X_W-1:0] : x_add[X_W-1:0];
               orient_d = OR_RIGHT;
            end
            state_d = S_DRAW;
         end
         S_DRAW: begin
            if (flush_q) begin
               flush_d = 1'b0;
               state_d = S_DONE;
            end else begin
               pix_run  = 1'b1;
               draw_v_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Raster counter; the cycle after the last pixel is a flush so the ROM output drains.
      if (pix_run) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
               row_d   = '0;
               flush_d = 1'b1;
            end else begin
               row_d = row_q + 5'd1;
            end
         end else begin
            col_d = col_q + 5'd1;
         end
      end
   end

   // Colour and plot use ROM data directly: it arrives in the same cycle as the registered address.
   assign plot    = erase_v_q | (draw_v_q & (pix_colour != TRANSP_C));
   assign colour  = draw_v_q ? pix_colour : (erase_v_q ? BG_C : '0);
   assign vga_x   = vga_x_q;
   assign vga_y   = vga_y_q;
   assign pix_col = col_q;
   assign pix_row = row_q;
   assign orient  = orient_q;
   assign pos_x   = pos_x_q;
   assign pos_y   = pos_y_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised sprite animator for the VGA game datapath. It sits between the keypad/controller inputs and the VGA adapter's plot port. It holds one sprite's on-screen position and heading. On each `go` it erases the old footprint, moves by a fixed step with screen-edge clamping, and redraws the sprite from an external orientation-indexed pixel ROM. One instance serves Pac-Man; further instances serve ghosts.

## Interface
Parameters:
- `X_W`, 8, x coordinate width
- `Y_W`, 7, y coordinate width
- `COL_W`, 3, colour width
- `SPR_W`, 20, sprite width in pixels
- `SPR_H`, 20, sprite height in pixels
- `STEP`, 7, pixels moved per `go`
- `SCREEN_W`, 160, screen width
- `SCREEN_H`, 120, screen height
- `INIT_X`, 0, reset x
- `INIT_Y`, 100, reset y
- `BG_COLOUR`, 0, erase colour
- `TRANSP`, 7, ROM colour treated as transparent

Ports:
- `clock` in 1: system clock
- `resetn` in 1: synchronous, active-low reset; clock `clock`
- `go` in 1: start one move/redraw; sampled only in IDLE
- `load` in 1: in IDLE, set position to `load_x`/`load_y`, clamped; `go` has priority over `load`
- `load_x` in X_W, `load_y` in Y_W: load position
- `left`, `right`, `up`, `down` in 1 each: active-low direction requests
- `pix_col` out 5, `pix_row` out 5: ROM pixel address
- `orient` out 2: ROM sprite select; 00 right, 01 left, 10 down, 11 up
- `pix_colour` in COL_W: ROM data, valid one cycle after the address
- `vga_x` out X_W, `vga_y` out Y_W, `colour` out COL_W, `plot` out 1: VGA write port
- `pos_x` out X_W, `pos_y` out Y_W: current top-left position
- `busy` out 1: high whenever not in IDLE
- `done` out 1: one-cycle pulse when the redraw completes

## Operation
- States: IDLE, ERASE, MOVE, DRAW, DONE.
  - IDLE on `go` goes to ERASE.
  - ERASE goes to MOVE after its last pixel plus one flush cycle.
  - MOVE always goes to DRAW.
  - DRAW goes to DONE after its last pixel plus one flush cycle.
  - DONE always goes to IDLE.
- Pixel counter: `pix_col` runs 0..SPR_W-1 fastest, `pix_row` 0..SPR_H-1, one pixel per cycle, then wraps to 0,0.
- Output stage: `vga_x = pos_x + pix_col`, `vga_y = pos_y + pix_row`, registered one cycle to match ROM latency.
- ERASE: `plot` = 1 for every pixel, `colour` = BG_COLOUR, at the old position.
- DRAW: `colour` = `pix_colour`; `plot` = 1 only when `pix_colour` != TRANSP.
- MOVE direction priority: up > down > left > right, with the requested direction low.
  - up: y = max(0, y−STEP)
  - down: y = min(SCREEN_H−SPR_H, y+STEP)
  - left: x = max(0, x−STEP)
  - right: x = min(SCREEN_W−SPR_W, x+STEP)
- Arithmetic is done at X_W+1 / Y_W+1 bits so under- and overflow are detected before clamping. No wrap-around.
- `orient` updates to the winning direction. With no key pressed, position and `orient` hold, and the sprite is still redrawn.
- Direction inputs are sampled only in the MOVE cycle.
- `go` and `load` are ignored while `busy`.

## Timing
- Reset values:
  - state IDLE
  - `pos_x` = INIT_X, `pos_y` = INIT_Y
  - `orient` = 00
  - `plot` = 0, `done` = 0, `busy` = 0
  - `vga_x`, `vga_y`, `colour` = 0
  - `pix_col`, `pix_row` = 0
- Timeline, with `go` sampled at edge 0:
  - ERASE occupies cycles 1..SPR_W·SPR_H+1.
  - MOVE is cycle SPR_W·SPR_H+2.
  - DRAW follows for SPR_W·SPR_H+1 cycles.
  - `done` is high in cycle 2·SPR_W·SPR_H+4; that is 804 for 20×20.
- `plot` trails its address by exactly one cycle. `plot` is 0 in IDLE, MOVE and DONE.
- `pos_x`/`pos_y` change only at the MOVE→DRAW edge, or one cycle after `load` in IDLE.
- Reset mid-operation: the next edge forces IDLE and all reset values; no partial `done` is issued.
- `go` held high re-triggers on the first IDLE cycle after DONE.

## Configuration
- `SPRITE_MOVER_ERASE_EN` defined: ERASE pass present, as described above.
- Not defined:
  - IDLE goes directly to MOVE and ERASE is not compiled.
  - `done` is high in cycle SPR_W·SPR_H+3 after `go`, which is 403 for 20×20.
  - The caller is responsible for clearing the background.

## Test plan
- Reset, then `go` with no keys, ROM returning 1: 400 erase plots with colour 0 at (0..19, 100..119), then 400 draw plots with colour 1 at the same rectangle, `done` at cycle 804, `pos` = (0,100).
- From (0,100), `right`=0, `go`: `pos_x` = 7 at DRAW start; first draw plot at (7,100); `orient` = 00.
- `load` (3,50), then `left`=0 and `go`: `pos_x` clamps to 0. `load` (137,50), then `right`=0 and `go`: `pos_x` = 140, clamped.
- `up`=0 and `left`=0 together from (50,50): `pos` becomes (50,43) and `orient` = 11. A following `go` with no key keeps `orient` = 11.
- ROM returns TRANSP for even `pix_col`: DRAW produces exactly 200 plots; ERASE still produces 400.
- Assert `resetn`=0 at DRAW cycle 100: next cycle `plot` = 0 and `busy` = 0, `pos` = (INIT_X, INIT_Y), and no `done` pulse.
